// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sa_pkg
// Description : State encoding and arithmetic helpers for the systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    // Full product width plus headroom for K_MAX accumulations.
    function automatic int acc_w_default(input int dw, input int k_max);
        return 2 * dw + $clog2(k_max);
    endfunction

    // Widens a pw-bit product held in the low bits of prod to 64 bits.
    function automatic logic [63:0] ext_prod(input logic [63:0] prod, input int pw,
                                             input bit is_signed);
        logic [63:0] w_ext;
        w_ext = prod;
        if (is_signed && prod[pw-1]) begin
            w_ext = prod | (~64'd0 << pw);
        end
        return w_ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
// Module      : sa_pe
// Description : Output-stationary MAC cell with registered a/b pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    input  logic [ACC_W-1:0] acc_in,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
    output logic [ACC_W-1:0] acc_out
);

    logic [2*DW-1:0]  w_a_ext;
    logic [2*DW-1:0]  w_b_ext;
    logic [2*DW-1:0]  w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [ACC_W-1:0] r_acc;

    if (SIGNED != 0) begin : g_signed
        assign w_a_ext = {{DW{a_in[DW-1]}}, a_in};
        assign w_b_ext = {{DW{b_in[DW-1]}}, b_in};
    end else begin : g_unsigned
        assign w_a_ext = {{DW{1'b0}}, a_in};
        assign w_b_ext = {{DW{1'b0}}, b_in};
    end

    // Low 2*DW bits of the extended-operand product are the exact product.
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'(ext_prod(64'(w_prod), 2 * DW, SIGNED != 0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (shift_en) begin
            r_acc <= acc_in;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
            r_a   <= a_in;
            r_b   <= b_in;
        end
    end

    assign a_out   = r_a;
    assign b_out   = r_b;
    assign acc_out = r_acc;

endmodule
`default_nettype wire

// File: rtl/sa_matmul_array.sv
`default_nettype none
// ============================================================================
// Module      : sa_matmul_array
// Description : NxN output-stationary systolic C = A*B engine with skewed
//               operand entry and a backpressured column-shift drain.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_matmul_array
    import sa_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int K_MAX  = 256,
    parameter int ACC_W  = acc_w_default(DW, K_MAX),
    parameter int SIGNED = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DW-1:0]            a_col,
    input  logic [N*DW-1:0]            b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*ACC_W-1:0]         out_vec,
    output logic                       out_last
);

    localparam int c_KW = $clog2(K_MAX + 1);
    localparam int c_FW = $clog2(2 * N);
    localparam int c_CW = (c_KW > c_FW) ? c_KW : c_FW;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [c_KW-1:0]  r_k;
    logic             w_en;
    logic             w_clr;
    logic             w_shift;
    logic             w_step;
    logic             w_load_done;
    logic             w_flush_done;
    logic             w_drain_last;
    logic [N*DW-1:0]  w_a_src;
    logic [N*DW-1:0]  w_b_src;
    logic [DW-1:0]    w_a_edge [N];
    logic [DW-1:0]    w_b_edge [N];
    logic [DW-1:0]    w_a_pe   [N][N];
    logic [DW-1:0]    w_b_pe   [N][N];
    logic [ACC_W-1:0] w_acc    [N][N];

    assign w_en    = ((r_state == c_ST_LOAD) && in_valid) || (r_state == c_ST_FLUSH);
    assign w_clr   = (r_state == c_ST_IDLE) && start;
    assign w_shift = (r_state == c_ST_DRAIN) && out_ready;
    assign w_step  = ((r_state == c_ST_LOAD) && in_valid) || (r_state == c_ST_FLUSH) || w_shift;

    assign w_load_done  = (r_cnt + c_CW'(1)) == c_CW'(r_k);
    assign w_flush_done = r_cnt == c_CW'(2 * N - 3);
    assign w_drain_last = r_cnt == c_CW'(N - 1);

    // Zeros are injected while flushing the wavefront through the grid.
    assign w_a_src = (r_state == c_ST_LOAD) ? a_col : '0;
    assign w_b_src = (r_state == c_ST_LOAD) ? b_row : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = (k_len != '0) ? c_ST_LOAD : c_ST_DRAIN;
            c_ST_LOAD:  if (in_valid && w_load_done) w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: if (w_flush_done) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (out_ready && w_drain_last) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // One counter serves beats, flush cycles and drain beats; it restarts on every transition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_k   <= '0;
        end else begin
            if (w_clr) r_k <= k_len;
            if (r_state != w_state_nxt) r_cnt <= '0;
            else if (w_step)            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign w_a_edge[gi] = w_a_src[gi*DW +: DW];
            assign w_b_edge[gi] = w_b_src[gi*DW +: DW];
        end else begin : g_delay
            logic [DW-1:0] r_a_sr [gi];
            logic [DW-1:0] r_b_sr [gi];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_sr[s] <= '0;
                        r_b_sr[s] <= '0;
                    end
                end else if (w_clr) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_sr[s] <= '0;
                        r_b_sr[s] <= '0;
                    end
                end else if (w_en) begin
                    r_a_sr[0] <= w_a_src[gi*DW +: DW];
                    r_b_sr[0] <= w_b_src[gi*DW +: DW];
                    for (int s = 1; s < gi; s++) begin
                        r_a_sr[s] <= r_a_sr[s-1];
                        r_b_sr[s] <= r_b_sr[s-1];
                    end
                end
            end
            assign w_a_edge[gi] = r_a_sr[gi-1];
            assign w_b_edge[gi] = r_b_sr[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0]    w_a_in;
            logic [DW-1:0]    w_b_in;
            logic [ACC_W-1:0] w_acc_in;
            if (gj == 0) begin : g_left
                assign w_a_in   = w_a_edge[gi];
                assign w_acc_in = '0;
            end else begin : g_inner
                assign w_a_in   = w_a_pe[gi][gj-1];
                assign w_acc_in = w_acc[gi][gj-1];
            end
            if (gi == 0) begin : g_top
                assign w_b_in = w_b_edge[gj];
            end else begin : g_below
                assign w_b_in = w_b_pe[gi-1][gj];
            end
            sa_pe #(
                .DW     (DW),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk      (clk),
                .rstn     (rstn),
                .en       (w_en),
                .clr      (w_clr),
                .shift_en (w_shift),
                .a_in     (w_a_in),
                .b_in     (w_b_in),
                .acc_in   (w_acc_in),
                .a_out    (w_a_pe[gi][gj]),
                .b_out    (w_b_pe[gi][gj]),
                .acc_out  (w_acc[gi][gj])
            );
        end
        assign out_vec[gi*ACC_W +: ACC_W] = w_acc[gi][N-1];
    end

    assign busy      = r_state != c_ST_IDLE;
    assign in_ready  = r_state == c_ST_LOAD;
    assign out_valid = r_state == c_ST_DRAIN;
    assign out_last  = (r_state == c_ST_DRAIN) && w_drain_last;

endmodule
`default_nettype wire

// File: tb/tb_sa_matmul_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_matmul_array
// Description : Directed self-checking bench; signed and unsigned instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_matmul_array;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  k_len = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_col = '0;
    logic [31:0] b_row = '0;
    logic        busy, in_ready, out_valid, out_last;
    logic [95:0] out_vec;
    logic        busy_u, in_ready_u, out_valid_u, out_last_u;
    logic [95:0] out_vec_u;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nbeats, t0, t_first, unstable;
    logic [31:0] a_beats [256];
    logic [31:0] b_beats [256];
    logic [95:0] cap_vec [8];
    logic [95:0] cap_vec_u [8];
    logic        cap_last [8];

    sa_matmul_array #(.N(4), .DW(8), .K_MAX(256), .SIGNED(1)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_last(out_last)
    );

    sa_matmul_array #(.N(4), .DW(8), .K_MAX(256), .SIGNED(0)) u_dut_u (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .busy(busy_u),
        .in_valid(in_valid), .in_ready(in_ready_u), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_vec(out_vec_u), .out_last(out_last_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic load_identity();
        for (int k = 0; k < 4; k++) begin
            a_beats[k] = 32'h1 << (8 * k);
            b_beats[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        end
    endtask

    // Start a run (t0 = cycle with start high) and stream k operand beats.
    task automatic run(input int k, input bit stall, input bit mid_start);
        int b;
        int guard;
        bit phase;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 9'(k);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        b = 0;
        guard = 0;
        phase = 1'b0;
        while (b < k && guard < 2000) begin
            guard++;
            if (stall && !phase) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                a_col = a_beats[b];
                b_row = b_beats[b];
            end
            start = mid_start && (b == 2);
            k_len = mid_start ? 9'd1 : 9'(k);
            @(posedge clk); #1;
            if (in_valid) b++;
            phase = !phase;
        end
        in_valid = 1'b0;
        start = 1'b0;
        a_col = '0;
        b_row = '0;
    endtask

    // Capture drain beats; out_ready is held low for 'hold' edges at the first beat.
    task automatic collect(input int hold);
        int guard;
        int held;
        bit done;
        logic [95:0] hv;
        logic hl;
        for (int i = 0; i < 8; i++) begin
            cap_vec[i] = 'x;
            cap_vec_u[i] = 'x;
            cap_last[i] = 1'bx;
        end
        nbeats = 0; t_first = -1; unstable = 0; held = 0; done = 1'b0; guard = 0;
        hv = '0; hl = 1'b0;
        out_ready = (hold == 0);
        while (!done && guard < 400) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                if (t_first < 0) begin
                    t_first = cyc;
                    hv = out_vec;
                    hl = out_last;
                end
                if (!out_ready) begin
                    if (out_vec !== hv || out_last !== hl) unstable++;
                    held++;
                    if (held > hold) out_ready = 1'b1;
                end
                if (out_ready) begin
                    if (nbeats < 8) begin
                        cap_vec[nbeats] = out_vec;
                        cap_vec_u[nbeats] = out_vec_u;
                        cap_last[nbeats] = out_last;
                    end
                    nbeats++;
                    if (out_last) done = 1'b1;
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        total++; if (out_vec !== 96'd0) begin bad++; $display("FAIL reset_out_vec: got %h want 0", out_vec); end
    endtask

    task automatic test_identity(input string tag);
        logic [95:0] ev;
        load_identity();
        run(4, 1'b0, 1'b0);
        collect(0);
        total++; if (t_first !== t0 + 11) begin bad++; $display("FAIL %s_latency: got %0d want 11", tag, t_first - t0); end
        total++; if (nbeats !== 4) begin bad++; $display("FAIL %s_beats: got %0d want 4", tag, nbeats); end
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) ev[i*24 +: 24] = 24'(4*i + 4 - m);
            total++; if (cap_vec[m] !== ev) begin bad++; $display("FAIL %s_vec%0d: got %h want %h", tag, m, cap_vec[m], ev); end
            total++; if (cap_last[m] !== (m == 3)) begin bad++; $display("FAIL %s_last%0d: got %b want %b", tag, m, cap_last[m], m == 3); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got busy=%b want 0", tag, busy); end
    endtask

    task automatic test_signedness();
        for (int k = 0; k < 4; k++) begin
            a_beats[k] = 32'hFFFF_FFFF;
            b_beats[k] = 32'h0202_0202;
        end
        run(4, 1'b0, 1'b0);
        collect(0);
        total++; if (nbeats !== 4) begin bad++; $display("FAIL sign_beats: got %0d want 4", nbeats); end
        for (int m = 0; m < 4; m++) begin
            total++; if (cap_vec[m] !== {4{24'hFFFFF8}}) begin bad++; $display("FAIL signed_vec%0d: got %h want %h", m, cap_vec[m], {4{24'hFFFFF8}}); end
            total++; if (cap_vec_u[m] !== {4{24'd2040}}) begin bad++; $display("FAIL unsigned_vec%0d: got %h want %h", m, cap_vec_u[m], {4{24'd2040}}); end
        end
    endtask

    task automatic test_input_stall();
        logic [95:0] ev;
        load_identity();
        run(4, 1'b1, 1'b0);
        collect(0);
        total++; if (t_first !== t0 + 15) begin bad++; $display("FAIL stall_latency: got %0d want 15", t_first - t0); end
        total++; if (nbeats !== 4) begin bad++; $display("FAIL stall_beats: got %0d want 4", nbeats); end
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) ev[i*24 +: 24] = 24'(4*i + 4 - m);
            total++; if (cap_vec[m] !== ev) begin bad++; $display("FAIL stall_vec%0d: got %h want %h", m, cap_vec[m], ev); end
        end
    endtask

    task automatic test_backpressure();
        logic [95:0] ev;
        load_identity();
        run(4, 1'b0, 1'b0);
        collect(3);
        total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        total++; if (nbeats !== 4) begin bad++; $display("FAIL bp_beats: got %0d want 4", nbeats); end
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) ev[i*24 +: 24] = 24'(4*i + 4 - m);
            total++; if (cap_vec[m] !== ev) begin bad++; $display("FAIL bp_vec%0d: got %h want %h", m, cap_vec[m], ev); end
            total++; if (cap_last[m] !== (m == 3)) begin bad++; $display("FAIL bp_last%0d: got %b want %b", m, cap_last[m], m == 3); end
        end
    endtask

    task automatic test_k_zero();
        run(0, 1'b0, 1'b0);
        collect(0);
        total++; if (t_first !== t0 + 1) begin bad++; $display("FAIL k0_latency: got %0d want 1", t_first - t0); end
        total++; if (nbeats !== 4) begin bad++; $display("FAIL k0_beats: got %0d want 4", nbeats); end
        for (int m = 0; m < 4; m++) begin
            total++; if (cap_vec[m] !== 96'd0) begin bad++; $display("FAIL k0_vec%0d: got %h want 0", m, cap_vec[m]); end
        end
        total++; if (cap_last[3] !== 1'b1) begin bad++; $display("FAIL k0_last: got %b want 1", cap_last[3]); end
    endtask

    task automatic test_mid_start();
        logic [95:0] ev;
        load_identity();
        run(4, 1'b0, 1'b1);
        collect(0);
        total++; if (t_first !== t0 + 11) begin bad++; $display("FAIL midstart_latency: got %0d want 11", t_first - t0); end
        total++; if (nbeats !== 4) begin bad++; $display("FAIL midstart_beats: got %0d want 4", nbeats); end
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) ev[i*24 +: 24] = 24'(4*i + 4 - m);
            total++; if (cap_vec[m] !== ev) begin bad++; $display("FAIL midstart_vec%0d: got %h want %h", m, cap_vec[m], ev); end
        end
    endtask

    task automatic test_k_max();
        for (int k = 0; k < 256; k++) begin
            a_beats[k] = 32'h8080_8080;
            b_beats[k] = 32'h8080_8080;
        end
        run(256, 1'b0, 1'b0);
        collect(0);
        total++; if (t_first !== t0 + 263) begin bad++; $display("FAIL kmax_latency: got %0d want 263", t_first - t0); end
        total++; if (nbeats !== 4) begin bad++; $display("FAIL kmax_beats: got %0d want 4", nbeats); end
        for (int m = 0; m < 4; m++) begin
            total++; if (cap_vec[m] !== {4{24'd4194304}}) begin bad++; $display("FAIL kmax_vec%0d: got %h want %h", m, cap_vec[m], {4{24'd4194304}}); end
            total++; if (cap_vec_u[m] !== {4{24'd4194304}}) begin bad++; $display("FAIL kmax_u_vec%0d: got %h want %h", m, cap_vec_u[m], {4{24'd4194304}}); end
        end
    endtask

    task automatic test_reset_flush();
        load_identity();
        run(4, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_state: got busy=%b out_valid=%b want 1/0", busy, out_valid); end
        rstn = 1'b0;
        #1;
        total++; if ({busy, in_ready, out_valid, out_last} !== 4'b0000) begin bad++; $display("FAIL abort_ctrl: got %b want 0000", {busy, in_ready, out_valid, out_last}); end
        total++; if (out_vec !== 96'd0) begin bad++; $display("FAIL abort_vec: got %h want 0", out_vec); end
        @(negedge clk);
        rstn = 1'b1;
        test_identity("rerun");
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        test_identity("ident");
        test_signedness();
        test_input_stall();
        test_backpressure();
        test_k_zero();
        test_mid_start();
        test_k_max();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
